// File: rtl/aes_pkg.sv
// Shared AES definitions: round-count constants, FSM state encoding and
// byte-level helpers for the column-major 128-bit block layout.
package aes_pkg;

    localparam int AES_NR_128 = 10;
    localparam int AES_NR_192 = 12;
    localparam int AES_NR_256 = 14;

    typedef enum logic [1:0] {
        IDLE,
        ROUND,
        FINAL,
        DONE
    } state_t;

    // s(r,c) lives at [127-8*(4c+r) -: 8]; byte 0 of the block is s(0,0).
    function automatic logic [7:0] byte_at(input logic [127:0] blk, input int r, input int c);
        return blk[127 - 8 * (4 * c + r) -: 8];
    endfunction

    function automatic logic [127:0] inv_shift_rows(input logic [127:0] blk);
        logic [127:0] res;
        res = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                res[127 - 8 * (4 * c + r) -: 8] = byte_at(blk, r, (c - r + 4) % 4);
            end
        end
        return res;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_inv_mix_columns.sv
// AES InvMixColumns on a full 128-bit state; purely combinational.
module aes_inv_mix_columns
    import aes_pkg::*;
(
    input  logic [127:0] d,
    output logic [127:0] q
);

    // Multiply by a constant built from the 8/4/2/1 bits of k (used for 9, b, d, e).
    function automatic logic [7:0] mul(input logic [7:0] a, input logic [3:0] k);
        logic [7:0] x2, x4, x8;
        x2 = xtime(a);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return (k[3] ? x8 : 8'h00) ^ (k[2] ? x4 : 8'h00) ^
               (k[1] ? x2 : 8'h00) ^ (k[0] ? a  : 8'h00);
    endfunction

    for (genvar c = 0; c < 4; c++) begin : g_col
        logic [7:0] a0, a1, a2, a3;
        assign a0 = d[127 - 32 * c -: 8];
        assign a1 = d[119 - 32 * c -: 8];
        assign a2 = d[111 - 32 * c -: 8];
        assign a3 = d[103 - 32 * c -: 8];

        assign q[127 - 32 * c -: 8] = mul(a0, 4'he) ^ mul(a1, 4'hb) ^ mul(a2, 4'hd) ^ mul(a3, 4'h9);
        assign q[119 - 32 * c -: 8] = mul(a0, 4'h9) ^ mul(a1, 4'he) ^ mul(a2, 4'hb) ^ mul(a3, 4'hd);
        assign q[111 - 32 * c -: 8] = mul(a0, 4'hd) ^ mul(a1, 4'h9) ^ mul(a2, 4'he) ^ mul(a3, 4'hb);
        assign q[103 - 32 * c -: 8] = mul(a0, 4'hb) ^ mul(a1, 4'hd) ^ mul(a2, 4'h9) ^ mul(a3, 4'he);
    end

endmodule

// File: rtl/aes_inv_sbox.sv
// Combinational AES inverse S-box, one byte in and one byte out.
module aes_inv_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);

    // Entry 0 sits in the top byte; each line holds 16 consecutive entries.
    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    assign y = INV_SBOX[2047 - 8 * int'(a) -: 8];

endmodule

// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES inverse cipher, one round per clock, round keys fetched from an
// external store by index in the same cycle.
module aes_inv_cipher_iter
    import aes_pkg::*;
#(
    parameter int NR  = AES_NR_128,
    parameter int RKW = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [127:0]   in_data,
    output logic [RKW-1:0] rk_idx,
    input  logic [127:0]   rk,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [127:0]   out_data,
    output logic           busy
);

    localparam logic [RKW-1:0] RK_LAST   = RKW'(NR);
    localparam logic [RKW-1:0] CTR_START = RKW'(NR - 1);
    localparam logic [RKW-1:0] CTR_LAST  = RKW'(1);

    state_t         state, state_next;
    logic [RKW-1:0] ctr, ctr_next;
    logic [127:0]   st, st_next;

    logic [127:0] sr, sb, ark, mc;

    assign sr = inv_shift_rows(st);

    for (genvar i = 0; i < 16; i++) begin : g_sbox
        aes_inv_sbox u_sbox (
            .a (sr[8 * i +: 8]),
            .y (sb[8 * i +: 8])
        );
    end

    assign ark = sb ^ rk;

    aes_inv_mix_columns u_inv_mix (
        .d (ark),
        .q (mc)
    );

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking so every register samples the same pre-edge values.
        if (rst) begin
            state <= IDLE;
            ctr   <= '0;
            st    <= '0;
        end else begin
            state <= state_next;
            ctr   <= ctr_next;
            st    <= st_next;
        end
    end

    always_comb begin
        // NOTE: every output gets a default first, so no path can infer a latch.
        state_next = state;
        ctr_next   = ctr;
        st_next    = st;
        rk_idx     = RK_LAST;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b1;

        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    st_next    = in_data ^ rk;
                    ctr_next   = CTR_START;
                    state_next = ROUND;
                end
            end
            ROUND: begin
                rk_idx   = ctr;
                st_next  = mc;
                ctr_next = ctr - RKW'(1);
                if (ctr == CTR_LAST) begin
                    state_next = FINAL;
                end
            end
            FINAL: begin
                // Last round skips InvMixColumns and takes key 0.
                rk_idx     = '0;
                st_next    = ark;
                state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign out_data = st;

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Bench for aes_inv_cipher_iter: a forward-AES model supplies keys and expected
// plaintexts; a scoreboard pairs accepted ciphertexts with emitted plaintexts.
module tb_aes_inv_cipher_iter;

    localparam int RKW = 4;

    typedef struct {
        logic [127:0] ct;
        logic [127:0] pt;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic           in_valid_a, in_ready_a, out_valid_a, out_ready_a, busy_a;
    logic [127:0]   in_data_a, rk_a, out_data_a;
    logic [RKW-1:0] rk_idx_a;
    logic           in_valid_b, in_ready_b, out_valid_b, out_ready_b, busy_b;
    logic [127:0]   in_data_b, rk_b, out_data_b;
    logic [RKW-1:0] rk_idx_b;

    logic [127:0] rks_a [0:14];
    logic [127:0] rks_b [0:14];
    logic [7:0]   sbox_t [0:255];
    logic [31:0]  w [0:59];

    assign rk_a = (rk_idx_a <= 4'd14) ? rks_a[rk_idx_a] : '0;
    assign rk_b = (rk_idx_b <= 4'd14) ? rks_b[rk_idx_b] : '0;

    aes_inv_cipher_iter #(.NR(10), .RKW(RKW)) dut_a (
        .clk (clk), .rst (rst),
        .in_valid (in_valid_a), .in_ready (in_ready_a), .in_data (in_data_a),
        .rk_idx (rk_idx_a), .rk (rk_a),
        .out_valid (out_valid_a), .out_ready (out_ready_a), .out_data (out_data_a),
        .busy (busy_a)
    );

    aes_inv_cipher_iter #(.NR(14), .RKW(RKW)) dut_b (
        .clk (clk), .rst (rst),
        .in_valid (in_valid_b), .in_ready (in_ready_b), .in_data (in_data_b),
        .rk_idx (rk_idx_b), .rk (rk_b),
        .out_valid (out_valid_b), .out_ready (out_ready_b), .out_data (out_data_b),
        .busy (busy_b)
    );

    int checks = 0;
    int failures = 0;
    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    logic [127:0] sb_a [$];
    logic [127:0] sb_b [$];
    logic [127:0] pend_a, pend_b;
    int n_acc_a = 0, n_acc_b = 0, last_acc_a = 0, last_acc_b = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s: expected event did not occur", name);
    endtask

    // ---------------- forward AES reference model ----------------
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = xt(a);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            if (x != 0) begin
                inv = 8'h01;
                for (int k = 0; k < 254; k++) inv = gmul(inv, 8'(x));
            end
            sbox_t[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] t);
        return {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
    endfunction

    task automatic expand(input logic [255:0] key, input int nk, input int nr);
        logic [31:0] t;
        logic [7:0]  rcon = 8'h01;
        for (int i = 0; i < 4 * (nr + 1); i++) begin
            if (i < nk) begin
                w[i] = key[255 - 32 * i -: 32];
            end else begin
                t = w[i - 1];
                if (i % nk == 0) begin
                    t = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
                    rcon = xt(rcon);
                end else if (nk > 6 && i % nk == 4) begin
                    t = sub_word(t);
                end
                w[i] = w[i - nk] ^ t;
            end
        end
    endtask

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        for (int i = 0; i < 16; i++) s[8 * i +: 8] = sbox_t[s[8 * i +: 8]];
        return s;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127 - 8 * (4 * c + r) -: 8] = s[127 - 8 * (4 * ((c + r) % 4) + r) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32 * c -: 8]; a1 = s[119 - 32 * c -: 8];
            a2 = s[111 - 32 * c -: 8]; a3 = s[103 - 32 * c -: 8];
            o[127 - 32 * c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
            o[119 - 32 * c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
            o[111 - 32 * c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
            o[103 - 32 * c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
        return o;
    endfunction

    function automatic logic [127:0] encrypt_a(input logic [127:0] pt);
        logic [127:0] s = pt ^ rks_a[0];
        for (int r = 1; r <= 10; r++) begin
            s = shift_rows(sub_bytes(s));
            if (r < 10) s = mix_columns(s);
            s = s ^ rks_a[r];
        end
        return s;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- scoreboard monitor (samples on falling edge) ----------------
    always @(negedge clk) begin
        if (!rst) begin
            if (in_valid_a && in_ready_a) begin
                sb_a.push_back(pend_a);
                last_acc_a = edge_cnt + 1;
                n_acc_a++;
            end
            if (out_valid_a && out_ready_a) begin
                if (sb_a.size() == 0) fail("sb_a_unexpected_output");
                else check("sb_a_plaintext", out_data_a, sb_a.pop_front());
            end
            if (in_valid_b && in_ready_b) begin
                sb_b.push_back(pend_b);
                last_acc_b = edge_cnt + 1;
                n_acc_b++;
            end
            if (out_valid_b && out_ready_b) begin
                if (sb_b.size() == 0) fail("sb_b_unexpected_output");
                else check("sb_b_plaintext", out_data_b, sb_b.pop_front());
            end
        end
    end

    // ---------------- drivers: inputs change 1ns after the rising edge ----------------
    task automatic send_a(input logic [127:0] ct, input logic [127:0] pt);
        int start = n_acc_a;
        int n = 0;
        @(posedge clk); #1;
        in_valid_a = 1'b1; in_data_a = ct; pend_a = pt;
        do begin @(posedge clk); #1; n++; end while (n_acc_a == start && n < 100);
        if (n_acc_a == start) fail("send_a_accept_timeout");
        in_valid_a = 1'b0; in_data_a = rnd128();
    endtask

    task automatic send_b(input logic [127:0] ct, input logic [127:0] pt);
        int start = n_acc_b;
        int n = 0;
        @(posedge clk); #1;
        in_valid_b = 1'b1; in_data_b = ct; pend_b = pt;
        do begin @(posedge clk); #1; n++; end while (n_acc_b == start && n < 100);
        if (n_acc_b == start) fail("send_b_accept_timeout");
        in_valid_b = 1'b0; in_data_b = rnd128();
    endtask

    // Returns the number of edges from the accept edge (inclusive) to out_valid.
    task automatic wait_out_a(output int lat);
        int n = 0;
        do begin @(negedge clk); n++; end while (!out_valid_a && n < 100);
        if (!out_valid_a) fail("wait_out_a_timeout");
        lat = edge_cnt - last_acc_a + 1;
    endtask

    task automatic wait_out_b(output int lat);
        int n = 0;
        do begin @(negedge clk); n++; end while (!out_valid_b && n < 100);
        if (!out_valid_b) fail("wait_out_b_timeout");
        lat = edge_cnt - last_acc_b + 1;
    endtask

    localparam logic [127:0] KEY128 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [255:0] KEY256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] PT_FIPS = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C1   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT_C3   = 128'h8ea2b7ca516745bfeafc49904b496089;

    vec_t vecs [5];

    initial begin
        int lat, e1, e2, start, n;
        logic [127:0] pt, ct;

        in_valid_a = 0; in_data_a = '0; out_ready_a = 1; pend_a = '0;
        in_valid_b = 0; in_data_b = '0; out_ready_b = 1; pend_b = '0;
        for (int i = 0; i < 15; i++) begin rks_a[i] = '0; rks_b[i] = '0; end

        build_sbox();
        expand({KEY128, 128'h0}, 4, 10);
        for (int r = 0; r <= 10; r++) rks_a[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        expand(KEY256, 8, 14);
        for (int r = 0; r <= 14; r++) rks_b[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};

        vecs[0].ct = CT_C1; vecs[0].pt = PT_FIPS;
        for (int i = 1; i < 5; i++) begin
            vecs[i].pt = rnd128();
            vecs[i].ct = encrypt_a(vecs[i].pt);
        end

        // Reset values
        #1 rst = 1'b1;
        #2;
        check("rst_in_ready", in_ready_a, 1);
        check("rst_out_valid", out_valid_a, 0);
        check("rst_out_data", out_data_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_rk_idx_a", rk_idx_a, 10);
        check("rst_rk_idx_b", rk_idx_b, 14);
        #9 rst = 1'b0;

        // FIPS-197 C.1 with rk_idx sequence and exact latency
        @(negedge clk);
        check("idle_rk_idx", rk_idx_a, 10);
        check("rk_first_request", rk_a, 128'h13111d7fe3944a17f307a78b4d2b30c5);
        send_a(CT_C1, PT_FIPS);
        for (int k = 0; k <= 10; k++) begin
            @(negedge clk);
            if (k <= 9) check("rk_idx_seq", rk_idx_a, (k < 9) ? 9 - k : 0);
            check("out_valid_timing", out_valid_a, (k == 10) ? 1 : 0);
        end
        check("c1_latency", edge_cnt - last_acc_a + 1, 11);
        check("c1_plaintext", out_data_a, PT_FIPS);

        // Table of vectors
        for (int i = 0; i < 5; i++) begin
            send_a(vecs[i].ct, vecs[i].pt);
            wait_out_a(lat);
            check("vec_plaintext", out_data_a, vecs[i].pt);
            check("vec_latency", lat, 11);
        end

        // Backpressure: 20 cycles in DONE with out_ready low
        @(posedge clk); #1 out_ready_a = 1'b0;
        pt = rnd128(); ct = encrypt_a(pt);
        send_a(ct, pt);
        wait_out_a(lat);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check("bp_out_data", out_data_a, pt);
            check("bp_out_valid", out_valid_a, 1);
            check("bp_in_ready", in_ready_a, 0);
            check("bp_busy", busy_a, 1);
        end
        @(posedge clk); #1 out_ready_a = 1'b1;
        @(negedge clk);
        check("bp_release_valid", out_valid_a, 1);
        @(negedge clk);
        check("bp_after_valid", out_valid_a, 0);
        check("bp_after_in_ready", in_ready_a, 1);
        check("bp_after_busy", busy_a, 0);
        check("bp_sb_empty", sb_a.size(), 0);

        // Back-to-back with in_valid held high
        @(posedge clk); #1;
        start = n_acc_a;
        vecs[1].pt = rnd128(); vecs[1].ct = encrypt_a(vecs[1].pt);
        vecs[2].pt = rnd128(); vecs[2].ct = encrypt_a(vecs[2].pt);
        in_valid_a = 1'b1; in_data_a = vecs[1].ct; pend_a = vecs[1].pt;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (n_acc_a == start && n < 50);
        e1 = last_acc_a;
        in_data_a = vecs[2].ct; pend_a = vecs[2].pt;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (n_acc_a < start + 2 && n < 50);
        e2 = last_acc_a;
        in_valid_a = 1'b0;
        if (n_acc_a < start + 2) fail("b2b_second_accept");
        else check("b2b_spacing", e2 - e1, 12);
        n = 0;
        do begin @(negedge clk); n++; end while ((sb_a.size() != 0 || out_valid_a) && n < 50);
        check("b2b_drained", sb_a.size(), 0);

        // Asynchronous reset in ROUND with ctr=5
        pt = rnd128(); ct = encrypt_a(pt);
        send_a(ct, pt);
        n = 0;
        while (!(busy_a && rk_idx_a == 4'd5) && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) fail("rst_mid_find_ctr5");
        #2 rst = 1'b1;
        #1;
        check("mid_rst_in_ready", in_ready_a, 1);
        check("mid_rst_out_valid", out_valid_a, 0);
        check("mid_rst_out_data", out_data_a, 0);
        check("mid_rst_busy", busy_a, 0);
        check("mid_rst_rk_idx", rk_idx_a, 10);
        sb_a.delete();
        #3 rst = 1'b0;
        send_a(CT_C1, PT_FIPS);
        wait_out_a(lat);
        check("post_rst_plaintext", out_data_a, PT_FIPS);
        check("post_rst_latency", lat, 11);

        // NR=14, FIPS-197 C.3
        send_b(CT_C3, PT_FIPS);
        wait_out_b(lat);
        check("c3_plaintext", out_data_b, PT_FIPS);
        check("c3_latency", lat, 15);

        // in_valid pulses during ROUND are ignored
        pt = rnd128(); ct = encrypt_a(pt);
        send_a(ct, pt);
        start = n_acc_a;
        for (int p = 0; p < 6; p++) begin
            @(posedge clk); #1;
            in_valid_a = (p % 2 == 0); in_data_a = rnd128();
            @(negedge clk);
            check("ign_in_ready", in_ready_a, 0);
        end
        @(posedge clk); #1 in_valid_a = 1'b0;
        wait_out_a(lat);
        check("ign_plaintext", out_data_a, pt);
        check("ign_no_accept", n_acc_a - start, 0);

        repeat (3) @(negedge clk);
        check("final_sb_a_empty", sb_a.size(), 0);
        check("final_sb_b_empty", sb_b.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
